// File: rtl/memwb_stage_v2_if.sv
// MEM/WB stage bus: EX/MEM slot handshake, memory read beats and the
// writeback port toward the register file.
interface memwb_if #(
  parameter int XLEN = 32
);
  logic            ex_valid_i;
  logic            ex_ready_o;
  logic [31:0]     ex_ir_i;
  logic [XLEN-1:0] ex_alu_i;
  logic            ex_mdu_valid_i;
  logic [XLEN-1:0] ex_mdu_result_i;
  logic            mem_rsp_valid_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            wb_valid_o;
  logic            wb_we_o;
  logic [4:0]      wb_rd_o;
  logic [XLEN-1:0] wb_data_o;

  // Upstream side: EX/MEM register and memory drive, writeback is observed
  modport master (
    output ex_valid_i, ex_ir_i, ex_alu_i, ex_mdu_valid_i, ex_mdu_result_i,
    output mem_rsp_valid_i, mem_rdata_i,
    input  ex_ready_o, wb_valid_o, wb_we_o, wb_rd_o, wb_data_o
  );

  // The stage itself
  modport slave (
    input  ex_valid_i, ex_ir_i, ex_alu_i, ex_mdu_valid_i, ex_mdu_result_i,
    input  mem_rsp_valid_i, mem_rdata_i,
    output ex_ready_o, wb_valid_o, wb_we_o, wb_rd_o, wb_data_o
  );
endinterface

// File: rtl/memwb_stage_v2.sv
// MEM/WB pipeline stage: valid/ready intake, load byte/half/word extraction,
// two-beat merge for loads that cross an XLEN boundary, flush with draining
// of responses still owed by the memory, and a retired-instruction counter.
//
// state    | meaning
// IDLE     | ready for a new instruction
// WAIT_ONE | aligned load, waiting for its single beat
// WAIT_LO  | crossing load, waiting for the low beat
// WAIT_HI  | crossing load, low beat held, waiting for the high beat
// DRAIN    | flushed load, swallowing beats still owed by memory
module memwb_stage_v2 #(
  parameter int XLEN       = 32,
  parameter bit ENABLE_MDU = 1'b1,
  parameter int CNT_W      = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  memwb_if.slave           bus,
  output logic [CNT_W-1:0] instret_o
);

  localparam int          BW  = XLEN / 8;
  localparam int          OW  = $clog2(BW);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0]  OP_LOAD = 7'b0000011;

  typedef enum logic [2:0] {IDLE, WAIT_ONE, WAIT_LO, WAIT_HI, DRAIN} state_t;

  state_t          state_q;
  logic [31:0]     ir_q;
  logic [OW-1:0]   off_q;
  logic [XLEN-1:0] lo_q;
  logic [1:0]      pending_q;
  logic [XLEN-1:0] ld_result;
  logic            is_load;
  logic            need2;

  // Access width in bytes; unknown encodings fall back to a full register.
  function automatic int load_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010, 3'b110: return 4;
      default:        return BW;
    endcase
  endfunction

  // Opcodes that produce a register result; SYSTEM only for CSR forms.
  function automatic logic writes_rd(input logic [31:0] ir);
    logic op_ok;
    case (ir[6:0])
      7'b0110011, 7'b0010011, 7'b0010111, 7'b0110111,
      7'b0000011, 7'b1101111, 7'b1100111: op_ok = 1'b1;
      7'b1110011:                         op_ok = (ir[14:12] != 3'b000);
      default:                            op_ok = 1'b0;
    endcase
    return op_ok && (ir[11:7] != 5'd0);
  endfunction

  // Shift the addressed byte down to bit 0, then size and extend it.
  function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] line,
                                               input logic [OW-1:0] off,
                                               input logic [2:0] f3);
    logic [2*XLEN-1:0] raw;
    raw = line >> {off, 3'b000};
    case (f3)
      3'b000:  return XLEN'($signed(raw[7:0]));
      3'b100:  return XLEN'(raw[7:0]);
      3'b001:  return XLEN'($signed(raw[15:0]));
      3'b101:  return XLEN'(raw[15:0]);
      3'b010:  return XLEN'($signed(raw[31:0]));
      3'b110:  return XLEN'(raw[31:0]);
      default: return raw[XLEN-1:0];
    endcase
  endfunction

  assign bus.ex_ready_o = (state_q == IDLE) && !flush_i;
  assign is_load        = (bus.ex_ir_i[6:0] == OP_LOAD);
  assign need2          = (int'(bus.ex_alu_i[OW-1:0]) + load_bytes(bus.ex_ir_i[14:12])) > BW;

  // Final load value from the beat(s) collected so far plus the current beat.
  always_comb begin
    ld_result = '0;
    if (state_q == WAIT_HI)
      ld_result = extract({bus.mem_rdata_i, lo_q}, off_q, ir_q[14:12]);
    else
      ld_result = extract({{XLEN{1'b0}}, bus.mem_rdata_i}, off_q, ir_q[14:12]);
  end

  // Stage sequencing, writeback registers and instret counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ir_q           <= NOP;
      off_q          <= '0;
      lo_q           <= '0;
      pending_q      <= '0;
      bus.wb_valid_o <= 1'b0;
      bus.wb_we_o    <= 1'b0;
      bus.wb_rd_o    <= '0;
      bus.wb_data_o  <= '0;
      instret_o      <= '0;
    end else begin
      bus.wb_valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ex_valid_i && bus.ex_ready_o) begin
            ir_q <= bus.ex_ir_i;
            if (is_load) begin
              off_q   <= bus.ex_alu_i[OW-1:0];
              state_q <= need2 ? WAIT_LO : WAIT_ONE;
            end else begin
              bus.wb_valid_o <= 1'b1;
              bus.wb_we_o    <= writes_rd(bus.ex_ir_i);
              bus.wb_rd_o    <= bus.ex_ir_i[11:7];
              bus.wb_data_o  <= (ENABLE_MDU && bus.ex_mdu_valid_i) ?
                                bus.ex_mdu_result_i : bus.ex_alu_i;
              instret_o      <= instret_o + 1'b1;
            end
          end
        end
        WAIT_ONE, WAIT_HI: begin
          if (flush_i) begin
            // one beat owed; if it lands now there is nothing left to drain
            pending_q <= 2'd1;
            state_q   <= bus.mem_rsp_valid_i ? IDLE : DRAIN;
          end else if (bus.mem_rsp_valid_i) begin
            bus.wb_valid_o <= 1'b1;
            bus.wb_we_o    <= writes_rd(ir_q);
            bus.wb_rd_o    <= ir_q[11:7];
            bus.wb_data_o  <= ld_result;
            instret_o      <= instret_o + 1'b1;
            state_q        <= IDLE;
          end
        end
        WAIT_LO: begin
          if (flush_i) begin
            pending_q <= bus.mem_rsp_valid_i ? 2'd1 : 2'd2;
            state_q   <= DRAIN;
          end else if (bus.mem_rsp_valid_i) begin
            lo_q    <= bus.mem_rdata_i;
            state_q <= WAIT_HI;
          end
        end
        DRAIN: begin
          if (bus.mem_rsp_valid_i) begin
            pending_q <= pending_q - 2'd1;
            if (pending_q == 2'd1) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
